// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode seven-segment scanner with PWM brightness,
// per-digit enable/dp, leading-zero blanking and a frame-aligned double buffer.

module seg_scan_digit (
  input  logic [3:0] nib,
  input  logic       zero_above,
  output logic       zero_here,
  output logic [6:0] code
);
  assign zero_here = zero_above && (nib == 4'h0);

  always_comb begin
    code = 7'h7F;
    unique case (nib)
      4'h0: code = 7'h01;  4'h1: code = 7'h4F;  4'h2: code = 7'h12;  4'h3: code = 7'h06;
      4'h4: code = 7'h4C;  4'h5: code = 7'h24;  4'h6: code = 7'h20;  4'h7: code = 7'h0F;
      4'h8: code = 7'h00;  4'h9: code = 7'h04;  4'hA: code = 7'h08;  4'hB: code = 7'h60;
      4'hC: code = 7'h31;  4'hD: code = 7'h42;  4'hE: code = 7'h30;  4'hF: code = 7'h38;
      default: code = 7'h7F;
    endcase
  end
endmodule

module seg_scan_mux #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 500,
  parameter int BRIGHT_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  output logic                      load_ack,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      blank_lz,
  input  logic [BRIGHT_W-1:0]       brightness,
  output logic                      frame_start,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp
);
  localparam int PW = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] nib;
    logic [NUM_DIGITS-1:0]      dp;
  } dbuf_t;

  dbuf_t                        shadow, active;
  logic                         pending;
  logic [PW-1:0]                pre;
  logic [BRIGHT_W-1:0]          sub;
  logic [IW-1:0]                idx;
  logic                         tick, sub_wrap, boundary, lit;
  logic [NUM_DIGITS:0]          zchain;
  logic [NUM_DIGITS-1:0]        blank;
  logic [NUM_DIGITS-1:0][6:0]   codes;
  logic [NUM_DIGITS-1:0]        an_nxt;

  assign tick     = (pre == PW'(CLK_DIV - 1));
  assign sub_wrap = tick && (sub == '1);
  assign boundary = sub_wrap && (idx == IW'(NUM_DIGITS - 1));

  // Zero-run chain flows from the most significant digit down; digit 0 never blanks.
  assign zchain[NUM_DIGITS] = 1'b1;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    seg_scan_digit u_dig (
      .nib       (active.nib[i]),
      .zero_above(zchain[i+1]),
      .zero_here (zchain[i]),
      .code      (codes[i])
    );
    assign blank[i] = (i != 0) && blank_lz && zchain[i];
  end

  // sub==0 is the ghost guard: always dark regardless of brightness.
  assign lit = (sub != '0) && (sub <= brightness) && digit_en[idx] && !blank[idx];

  always_comb begin
    an_nxt      = '1;
    an_nxt[idx] = ~lit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre         <= '0;
      sub         <= '0;
      idx         <= '0;
      shadow      <= '0;
      active      <= '0;
      pending     <= 1'b0;
      an          <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) sub <= sub + 1'b1;
      if (sub_wrap) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

      // Swap takes the pre-write shadow; a same-cycle load stays pending.
      if (boundary && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (load) begin
        shadow.nib <= data_in;
        shadow.dp  <= dp_in;
        pending    <= 1'b1;
      end

      an          <= an_nxt;
      seg         <= lit ? codes[idx] : 7'h7F;
      dp          <= lit ? ~active.dp[idx] : 1'b1;
      load_ack    <= boundary && pending;
      frame_start <= (idx == '0) && (sub == '0) && (pre == '0);
    end
  end
endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized + directed scoreboard bench for seg_scan_mux (4 digits, CLK_DIV=2, BRIGHT_W=2).

module tb_seg_scan_mux;
  localparam int N = 4, CD = 2, BW = 2, S = 4, SLOT = CD * S, FRAME = N * SLOT;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic [4*N-1:0]  data_in = '0;
  logic [N-1:0]    dp_in = '0, digit_en = 4'hF, an;
  logic            load = 1'b0, blank_lz = 1'b0, load_ack, frame_start, dp;
  logic [BW-1:0]   brightness = 2'd3;
  logic [6:0]      seg;

  seg_scan_mux #(.NUM_DIGITS(N), .CLK_DIV(CD), .BRIGHT_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .load(load),
    .load_ack(load_ack), .digit_en(digit_en), .blank_lz(blank_lz),
    .brightness(brightness), .frame_start(frame_start), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    logic         ack;
    logic         fs;
  } obs_t;

  obs_t q[$];
  int   vectors = 0, errors = 0;
  int   mp = 0;
  logic [15:0] sh_d = '0, ac_d = '0;
  logic [3:0]  sh_p = '0, ac_p = '0;
  bit          pend = 0;

  function automatic logic [6:0] hexseg(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                           7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    return t[v];
  endfunction

  // Reference model: display position mp within the frame drives everything.
  initial forever begin
    obs_t e;
    int sub, idx;
    bit lit, bound, blk;
    @(posedge clk);
    if (!rst_n) begin
      e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ack: 1'b0, fs: 1'b0};
      sh_d = '0; ac_d = '0; sh_p = '0; ac_p = '0; pend = 0; mp = 0;
    end else begin
      sub   = (mp / CD) % S;
      idx   = (mp / SLOT) % N;
      bound = (mp % FRAME) == FRAME - 1;
      blk   = blank_lz && idx > 0 && ((ac_d >> (4 * idx)) == 16'h0);
      lit   = sub >= 1 && sub <= int'(brightness) && digit_en[idx] && !blk;
      e.an  = lit ? ~(4'b0001 << idx) : 4'hF;
      e.seg = lit ? hexseg(ac_d[4*idx +: 4]) : 7'h7F;
      e.dp  = lit ? ~ac_p[idx] : 1'b1;
      e.ack = bound && pend;
      e.fs  = (mp % FRAME) == 0;
      if (bound && pend) begin ac_d = sh_d; ac_p = sh_p; pend = 0; end
      if (load) begin sh_d = data_in; sh_p = dp_in; pend = 1; end
      mp++;
    end
    q.push_back(e);
  end

  initial forever begin
    obs_t e, a;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{an: an, seg: seg, dp: dp, ack: load_ack, fs: frame_start};
      vectors++;
      if (a !== e) begin
        errors++;
        $display("FAIL obs t=%0t an=%h/%h seg=%h/%h dp=%b/%b ack=%b/%b fs=%b/%b (got/exp)",
                 $time, a.an, e.an, a.seg, e.seg, a.dp, e.dp, a.ack, e.ack, a.fs, e.fs);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data_in = d; dp_in = p; load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  // Position the next edge on the frame wrap cycle (bounded).
  task automatic align_wrap();
    int n = 0;
    while ((mp % FRAME) != FRAME - 1 && n < FRAME + 2) begin cyc(1); n++; end
    vectors++;
    if ((mp % FRAME) != FRAME - 1) begin
      errors++;
      $display("FAIL align_wrap pos=%0d need=%0d", mp % FRAME, FRAME - 1);
    end
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    // first frames
    do_load(16'h1234, 4'b0000);
    cyc(3 * FRAME);
    // tear-free mid-frame update
    cyc(10);
    do_load(16'hABCD, 4'b0101);
    cyc(3 * FRAME);
    // load exactly on the wrap with nothing pending
    align_wrap();
    do_load(16'h5678, 4'b0000);
    cyc(3 * FRAME);
    // leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0050, 4'b0000);
    cyc(3 * FRAME);
    do_load(16'h0000, 4'b0001);
    cyc(2 * FRAME);
    blank_lz = 1'b0;
    // brightness and mask
    brightness = 2'd0;
    do_load(16'h1234, 4'b0010);
    cyc(2 * FRAME);
    brightness = 2'd1; digit_en = 4'b1010;
    cyc(2 * FRAME);
    brightness = 2'd3; digit_en = 4'hF;
    // reset in flight before boundary
    do_load(16'h9999, 4'b1111);
    cyc(5);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2 * FRAME);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      load       = ($urandom_range(0, 19) == 0);
      data_in    = 16'($urandom);
      dp_in      = 4'($urandom);
      if ($urandom_range(0, 49) == 0) brightness = 2'($urandom);
      if ($urandom_range(0, 99) == 0) digit_en   = 4'($urandom);
      if ($urandom_range(0, 99) == 0) blank_lz   = 1'($urandom);
      rst_n      = ($urandom_range(0, 599) != 0);
      cyc(1);
    end
    load = 1'b0; rst_n = 1'b1;
    cyc(FRAME);
    @(negedge clk); #1;
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d need=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
